mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single 8-bit memory port (address, to_memory, write, from_memory) between two bus masters: the cpu and a second master such as a program loader, DMA or debug port.
- Each master issues one transaction at a time over a req/ack handshake.
- The arbiter picks one owner, sequences the memory access (a write pulse, or a read with fixed latency) and returns read data plus a one-cycle ack.

Parameters:
- ADDR_W, 8, address width.
- DATA_W, 8, data width.
- MEM_LAT, 1, read latency of memory in cycles; legal 1..7.
- FIXED_PRIO, 0, 0 = round-robin, 1 = m0 always wins ties.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- m0_req  input  1  master 0 request; held with m0_we/m0_addr/m0_wdata stable until m0_ack.
- m0_we  input  1  1 = write, 0 = read.
- m0_addr  input  ADDR_W  transaction address.
- m0_wdata  input  DATA_W  write data.
- m0_gnt  output  1  master 0 owns the bus.
- m0_ack  output  1  one-cycle completion pulse.
- m0_rdata  output  DATA_W  read data, valid from the m0_ack cycle until the next m0 read.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_ack, m1_rdata  same as m0_*, for master 1.
- address  output  ADDR_W  memory address.
- to_memory  output  DATA_W  memory write data.
- write  output  1  memory write strobe.
- from_memory  input  DATA_W  memory read data.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (synchronous, active-high) forces the following on the next clock edge; reset dominates all other inputs:
  - state = IDLE, wait counter = 0.
  - All outputs = 0.
  - last_served = 1, so m0 wins the first tie.
- State machine IDLE -> ISSUE -> (WAIT) -> DONE -> IDLE. All outputs are registered.
- IDLE:
  - If no req is asserted, remain in IDLE.
  - Otherwise select the owner:
    - Only one req asserted: that master.
    - Both asserted, FIXED_PRIO=0: the master that is not last_served.
    - Both asserted, FIXED_PRIO=1: m0.
  - On the same edge, latch the owner's addr into address and wdata into to_memory. Set write = owner's we, set owner gnt = 1, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - address and to_memory are stable; write is 1 only for a write transaction.
  - On exit, clear write and load the wait counter with MEM_LAT.
  - Write transaction: go to DONE. Read transaction: go to WAIT.
- WAIT:
  - address stays stable; the counter decrements each cycle.
  - When the counter reaches 1, capture from_memory into the owner's rdata on that edge and go to DONE.
  - WAIT lasts exactly MEM_LAT cycles.
- DONE (1 cycle):
  - Owner ack = 1.
  - On exit: gnt = 0, last_served = owner, return to IDLE.
  - The non-owner's gnt, ack and rdata are never touched.
- Latency, counted from the edge that samples req in IDLE (cycle 0):
  - Write: write pulse in cycle 1, ack in cycle 2.
  - Read: ack in cycle 2+MEM_LAT.
  - Minimum one IDLE cycle between transactions.
- Handshake:
  - A req still high in the cycle after ack is a new transaction.
  - Requests are not sampled outside IDLE.
  - A req dropped mid-transaction is a protocol violation. The transaction still completes and ack still pulses.
- gnt is high for the owner from ISSUE through DONE inclusive. m0_gnt and m1_gnt are never both 1.
- After a transaction, address and to_memory hold their last values. write is 0 outside ISSUE.
- A write never modifies rdata.
- Reset mid-transaction: the in-flight access is discarded, no ack is issued, and write drops on the next edge.

Test Plan:
- Reset, then m0 write with addr=0x10, wdata=0xA5 -> cycle 1: address=0x10, to_memory=0xA5, write=1 for exactly one cycle. Cycle 2: m0_ack=1. m0_gnt high in cycles 1-2. m1_* outputs stay 0.
- MEM_LAT=1, memory model holds 0xA5 at 0x10, m1 read of addr 0x10 -> write stays 0, m1_ack in cycle 3 with m1_rdata=0xA5, m0_rdata unchanged.
- FIXED_PRIO=0, both req held continuously with writes to 0x01 (m0) and 0x02 (m1) -> first owner m0, then strict alternation m0,m1,m0,m1 (address sequence 0x01,0x02,0x01,0x02). One idle cycle between transactions; gnts never overlap.
- FIXED_PRIO=1, both req held for 20 cycles -> only m0 is served; m1_gnt and m1_ack stay 0. After m0_req drops, m1 is served next.
- MEM_LAT=3, m0 read of addr 0x20 with memory returning 0x3C -> m0_ack in cycle 5, m0_rdata=0x3C, busy high in cycles 1-5.
- m1 read started with MEM_LAT=3, reset asserted in the second WAIT cycle -> next edge: all outputs 0, busy=0, no m1_ack ever. Then m0 and m1 request together -> m0 is granted first.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for a single memory port. One master owns the bus per
// transaction; the arbiter drives the memory address/data/strobe, waits the
// fixed read latency, returns read data and pulses a one-cycle ack.
module mem_bus_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int MEM_LAT    = 1,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] to_memory,
  output logic              write,
  input  logic [DATA_W-1:0] from_memory,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  // Wait counter is 3 bits wide, enough for latencies 1..7.
  localparam logic [2:0] LAT = 3'(MEM_LAT);

  state_t              r_state;
  state_t              w_next_state;
  logic                w_start;
  logic                w_sel;
  logic                w_capture;

  logic                r_owner;
  logic                r_last;
  logic                r_we;
  logic [2:0]          r_cnt;
  logic                r_m0_gnt;
  logic                r_m1_gnt;
  logic                r_m0_ack;
  logic                r_m1_ack;
  logic [DATA_W-1:0]   r_m0_rdata;
  logic [DATA_W-1:0]   r_m1_rdata;
  logic [ADDR_W-1:0]   r_address;
  logic [DATA_W-1:0]   r_to_memory;
  logic                r_write;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic, owner selection and read-capture decision.
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_sel        = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      IDLE: begin
        if (m0_req || m1_req) begin
          w_start      = 1'b1;
          w_next_state = ISSUE;
          if (m0_req && m1_req)
            w_sel = (FIXED_PRIO != 0) ? 1'b0 : ~r_last;  // tie: fixed m0, or whoever was not served last
          else
            w_sel = m1_req;
        end
      end
      ISSUE: w_next_state = r_we ? DONE : WAIT;
      WAIT: begin
        // Counter value 1 marks the last latency cycle; <=1 also guards a zero load.
        if (r_cnt <= 3'd1) begin
          w_capture    = 1'b1;
          w_next_state = DONE;
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Registered outputs: memory port, grants, acks, read data and bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner     <= 1'b0;
      r_last      <= 1'b1;
      r_we        <= 1'b0;
      r_cnt       <= 3'd0;
      r_m0_gnt    <= 1'b0;
      r_m1_gnt    <= 1'b0;
      r_m0_ack    <= 1'b0;
      r_m1_ack    <= 1'b0;
      r_m0_rdata  <= '0;
      r_m1_rdata  <= '0;
      r_address   <= '0;
      r_to_memory <= '0;
      r_write     <= 1'b0;
    end else begin
      r_m0_ack <= 1'b0;
      r_m1_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_owner     <= w_sel;
            r_address   <= w_sel ? m1_addr  : m0_addr;
            r_to_memory <= w_sel ? m1_wdata : m0_wdata;
            r_we        <= w_sel ? m1_we    : m0_we;
            r_write     <= w_sel ? m1_we    : m0_we;
            if (w_sel) r_m1_gnt <= 1'b1;
            else       r_m0_gnt <= 1'b1;
          end
        end
        ISSUE: begin
          r_write <= 1'b0;
          r_cnt   <= LAT;
          if (r_we) begin
            if (r_owner) r_m1_ack <= 1'b1;
            else         r_m0_ack <= 1'b1;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 3'd1;
          if (w_capture) begin
            if (r_owner) begin
              r_m1_rdata <= from_memory;
              r_m1_ack   <= 1'b1;
            end else begin
              r_m0_rdata <= from_memory;
              r_m0_ack   <= 1'b1;
            end
          end
        end
        DONE: begin
          r_last <= r_owner;
          if (r_owner) r_m1_gnt <= 1'b0;
          else         r_m0_gnt <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign m0_gnt    = r_m0_gnt;
  assign m0_ack    = r_m0_ack;
  assign m0_rdata  = r_m0_rdata;
  assign m1_gnt    = r_m1_gnt;
  assign m1_ack    = r_m1_ack;
  assign m1_rdata  = r_m1_rdata;
  assign address   = r_address;
  assign to_memory = r_to_memory;
  assign write     = r_write;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter. Three instances cover the parameter
// sets needed (round-robin lat 1, round-robin lat 3, fixed priority lat 1);
// all share the master inputs and the monitor observes the selected one.
module tb_mem_bus_arbiter;

  typedef struct {
    bit         m;
    logic [7:0] a;
    logic [7:0] d;
    int         cyc;
  } wr_t;

  typedef struct {
    bit         m;
    bit         rd;
    logic [7:0] rdata;
    int         cyc;
  } ack_t;

  logic       clk;
  logic       reset;
  logic       m0_req, m0_we, m1_req, m1_we;
  logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;

  logic [2:0] g0, a0, g1, a1, wr, bz;
  logic [7:0] rd0 [3];
  logic [7:0] rd1 [3];
  logic [7:0] ad  [3];
  logic [7:0] tm  [3];
  logic [7:0] fm  [3];
  logic [7:0] mem [256];

  int sel;
  int cyc;
  int checks;
  int failures;

  wr_t  exp_wr [$];
  ack_t exp_ack[$];
  wr_t  mon_w;
  ack_t mon_a;

  mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(1), .FIXED_PRIO(0)) u_d0 (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(g0[0]), .m0_ack(a0[0]), .m0_rdata(rd0[0]),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(g1[0]), .m1_ack(a1[0]), .m1_rdata(rd1[0]),
    .address(ad[0]), .to_memory(tm[0]), .write(wr[0]), .from_memory(fm[0]), .busy(bz[0]));

  mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(3), .FIXED_PRIO(0)) u_d1 (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(g0[1]), .m0_ack(a0[1]), .m0_rdata(rd0[1]),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(g1[1]), .m1_ack(a1[1]), .m1_rdata(rd1[1]),
    .address(ad[1]), .to_memory(tm[1]), .write(wr[1]), .from_memory(fm[1]), .busy(bz[1]));

  mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(1), .FIXED_PRIO(1)) u_d2 (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(g0[2]), .m0_ack(a0[2]), .m0_rdata(rd0[2]),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(g1[2]), .m1_ack(a1[2]), .m1_rdata(rd1[2]),
    .address(ad[2]), .to_memory(tm[2]), .write(wr[2]), .from_memory(fm[2]), .busy(bz[2]));

  // Memory model: combinational read per instance, writes from the observed one.
  assign fm[0] = mem[ad[0]];
  assign fm[1] = mem[ad[1]];
  assign fm[2] = mem[ad[2]];

  logic       s_m0g, s_m0a, s_m1g, s_m1a, s_wr, s_busy;
  logic [7:0] s_rd0, s_rd1, s_addr, s_tm;
  assign s_m0g  = g0[sel];
  assign s_m0a  = a0[sel];
  assign s_m1g  = g1[sel];
  assign s_m1a  = a1[sel];
  assign s_wr   = wr[sel];
  assign s_busy = bz[sel];
  assign s_rd0  = rd0[sel];
  assign s_rd1  = rd1[sel];
  assign s_addr = ad[sel];
  assign s_tm   = tm[sel];

  always @(posedge clk) begin
    if (s_wr) mem[s_addr] <= s_tm;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: pops and compares whenever the DUT strobes write or an ack.
  always @(negedge clk) begin
    if (!reset) begin
      if (s_wr) begin
        if (exp_wr.size() == 0) begin
          chk("unexpected_write", 64'(1), 64'(0));
        end else begin
          mon_w = exp_wr.pop_front();
          chk("wr_addr", 64'(s_addr), 64'(mon_w.a));
          chk("wr_data", 64'(s_tm), 64'(mon_w.d));
          chk("wr_cycle", 64'(cyc), 64'(mon_w.cyc));
          chk("wr_gnt", 64'({s_m1g, s_m0g}), mon_w.m ? 64'(2) : 64'(1));
        end
      end
      if (s_m0a || s_m1a) begin
        chk("single_ack", 64'(s_m0a && s_m1a), 64'(0));
        if (exp_ack.size() == 0) begin
          chk("unexpected_ack", 64'({s_m1a, s_m0a}), 64'(0));
        end else begin
          mon_a = exp_ack.pop_front();
          chk("ack_master", 64'(s_m1a), 64'(mon_a.m));
          chk("ack_cycle", 64'(cyc), 64'(mon_a.cyc));
          chk("ack_gnt", 64'({s_m1g, s_m0g}), mon_a.m ? 64'(2) : 64'(1));
          if (mon_a.rd)
            chk("rdata", mon_a.m ? 64'(s_rd1) : 64'(s_rd0), 64'(mon_a.rdata));
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic outs_zero(input string name);
    chk(name, 64'({s_m0g, s_m0a, s_rd0, s_m1g, s_m1a, s_rd1, s_addr, s_tm, s_wr, s_busy}), 64'(0));
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    m0_req = 1'b0;
    m1_req = 1'b0;
    tick();
    tick();
    outs_zero("reset_outputs");
    reset = 1'b0;
  endtask

  task automatic set_m0(input logic req, input logic we, input logic [7:0] a, input logic [7:0] d);
    m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d;
  endtask

  task automatic set_m1(input logic req, input logic we, input logic [7:0] a, input logic [7:0] d);
    m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d;
  endtask

  // n0 is the cyc value right after the edge that samples the request.
  task automatic push_txn(input bit m, input bit we, input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] rdat, input int n0, input int lat);
    if (we) begin
      exp_wr.push_back('{m: m, a: a, d: d, cyc: n0});
      exp_ack.push_back('{m: m, rd: 1'b0, rdata: 8'h00, cyc: n0 + 1});
    end else begin
      exp_ack.push_back('{m: m, rd: 1'b1, rdata: rdat, cyc: n0 + 1 + lat});
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_wr.size() != 0 || exp_ack.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    if (exp_wr.size() != 0 || exp_ack.size() != 0) begin
      chk("drain_timeout", 64'(exp_wr.size() + exp_ack.size()), 64'(0));
      exp_wr.delete();
      exp_ack.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    checks = 0; failures = 0; cyc = 0; sel = 0;
    reset = 1'b1;
    set_m0(1'b0, 1'b0, 8'h00, 8'h00);
    set_m1(1'b0, 1'b0, 8'h00, 8'h00);

    // Round-robin, latency 1: single write, then read-back by the other master.
    sel = 0;
    do_reset();
    set_m0(1'b1, 1'b1, 8'h10, 8'hA5);
    push_txn(1'b0, 1'b1, 8'h10, 8'hA5, 8'h00, cyc + 1, 1);
    drain(20);
    m0_req = 1'b0;
    tick();
    set_m1(1'b1, 1'b0, 8'h10, 8'h00);
    push_txn(1'b1, 1'b0, 8'h10, 8'h00, 8'hA5, cyc + 1, 1);
    drain(20);
    m1_req = 1'b0;
    chk("m0_rdata_untouched", 64'(s_rd0), 64'(0));
    tick();
    tick();
    chk("m1_rdata_held", 64'(s_rd1), 64'(8'hA5));
    chk("idle_busy", 64'(s_busy), 64'(0));

    // Round-robin with both requests held: strict alternation starting at m0.
    do_reset();
    set_m0(1'b1, 1'b1, 8'h01, 8'h11);
    set_m1(1'b1, 1'b1, 8'h02, 8'h22);
    n0 = cyc + 1;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) push_txn(1'b0, 1'b1, 8'h01, 8'h11, 8'h00, n0 + 3 * k, 1);
      else            push_txn(1'b1, 1'b1, 8'h02, 8'h22, 8'h00, n0 + 3 * k, 1);
    end
    drain(40);
    m0_req = 1'b0;
    m1_req = 1'b0;
    tick();
    tick();

    // Latency 3: write then read back, with busy checked every cycle of the read.
    sel = 1;
    do_reset();
    set_m0(1'b1, 1'b1, 8'h20, 8'h3C);
    push_txn(1'b0, 1'b1, 8'h20, 8'h3C, 8'h00, cyc + 1, 3);
    drain(20);
    m0_req = 1'b0;
    tick();
    set_m0(1'b1, 1'b0, 8'h20, 8'h00);
    n0 = cyc + 1;
    push_txn(1'b0, 1'b0, 8'h20, 8'h00, 8'h3C, n0, 3);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("busy_read", 64'(s_busy), 64'(cyc >= n0 && cyc <= n0 + 4));
      if (cyc == n0 + 4) m0_req = 1'b0;
    end
    drain(10);

    // Reset during the second WAIT cycle of an m1 read: no ack, outputs cleared.
    set_m1(1'b1, 1'b0, 8'h20, 8'h00);
    n0 = cyc + 1;
    tick();
    tick();
    tick();
    chk("in_wait_busy", 64'(s_busy), 64'(1));
    reset = 1'b1;
    tick();
    outs_zero("midreset_outputs");
    m1_req = 1'b0;
    reset  = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    set_m0(1'b1, 1'b1, 8'h30, 8'h5A);
    set_m1(1'b1, 1'b1, 8'h31, 8'h6B);
    n0 = cyc + 1;
    push_txn(1'b0, 1'b1, 8'h30, 8'h5A, 8'h00, n0, 3);
    push_txn(1'b1, 1'b1, 8'h31, 8'h6B, 8'h00, n0 + 3, 3);
    drain(30);
    m0_req = 1'b0;
    m1_req = 1'b0;
    tick();
    tick();

    // Fixed priority: m0 monopolises the bus while it keeps requesting.
    sel = 2;
    do_reset();
    set_m0(1'b1, 1'b1, 8'h01, 8'h11);
    set_m1(1'b1, 1'b1, 8'h02, 8'h22);
    n0 = cyc + 1;
    for (int k = 0; k < 7; k++) push_txn(1'b0, 1'b1, 8'h01, 8'h11, 8'h00, n0 + 3 * k, 1);
    drain(40);
    m0_req = 1'b0;
    push_txn(1'b1, 1'b1, 8'h02, 8'h22, 8'h00, cyc + 2, 1);
    drain(20);
    m1_req = 1'b0;
    tick();
    tick();
    tick();
    chk("final_busy", 64'(s_busy), 64'(0));
    chk("final_queues", 64'(exp_wr.size() + exp_ack.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
